pito_hart_scheduler: RTL and testbench

- Barrel-slot scheduler for the pito rv32 core.
- Walks hart slots in fixed round-robin order, one slot per cycle, and issues the slot's hart to fetch when that hart is eligible. Otherwise it issues a bubble, which preserves the fixed pipeline spacing between instructions of the same hart.
- Owns per-hart lifecycle (idle/boot/run/halted) and the boot-PC handshake used by the host/testbench to start harts.

---
 rtl/pito_hart_scheduler.sv | 146 ++++++++++++++
 tb/tb_pito_hart_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pito_hart_scheduler.sv
// Barrel-slot hart scheduler for the pito rv32 core: round-robin slot walk, per-hart lifecycle, boot-PC handshake.
// Optional per-hart issue / global bubble counters are enabled by defining PITO_SCHED_PERF_EN.
module pito_hart_scheduler #(
  parameter int NUM_HARTS = 8,
  parameter int HART_ID_W = $clog2(NUM_HARTS),
  parameter int PC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [HART_ID_W-1:0] start_hart,
  input  logic [PC_W-1:0]      start_pc,
  input  logic [NUM_HARTS-1:0] halt_req,
  input  logic [NUM_HARTS-1:0] hart_stall,
  output logic                 issue_valid,
  output logic [HART_ID_W-1:0] issue_hart,
  output logic                 issue_boot,
  output logic [PC_W-1:0]      issue_pc,
  output logic [NUM_HARTS-1:0] hart_running,
  output logic                 all_halted
`ifdef PITO_SCHED_PERF_EN
  ,
  input  logic [HART_ID_W-1:0] perf_sel,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOOT   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } hart_state_e;

  logic [HART_ID_W-1:0] slot_q;
  hart_state_e          state_q   [NUM_HARTS];
  hart_state_e          state_d   [NUM_HARTS];
  logic [PC_W-1:0]      boot_pc_q [NUM_HARTS];
  logic [PC_W-1:0]      boot_pc_d [NUM_HARTS];

  logic                 issue_valid_q;
  logic [HART_ID_W-1:0] issue_hart_q;
  logic                 issue_boot_q;
  logic [PC_W-1:0]      issue_pc_q;

  logic                 slot_active;
  logic                 slot_elig;
  logic                 slot_boot;
  logic                 start_fire;

  // Eligibility of the current slot's hart and the start handshake.
  always_comb begin
    slot_active = (state_q[slot_q] == ST_BOOT) || (state_q[slot_q] == ST_RUN);
    slot_elig   = slot_active && !hart_stall[slot_q] && !halt_req[slot_q];
    slot_boot   = slot_elig && (state_q[slot_q] == ST_BOOT);
    start_ready = (state_q[start_hart] == ST_IDLE) || (state_q[start_hart] == ST_HALTED);
    start_fire  = start_valid && start_ready;
  end

  // Per-hart next state and status flags; halt wins because start can only target IDLE/HALTED harts.
  always_comb begin
    hart_running = '0;
    all_halted   = 1'b1;
    for (int h = 0; h < NUM_HARTS; h++) begin
      state_d[h]   = state_q[h];
      boot_pc_d[h] = boot_pc_q[h];
      case (state_q[h])
        ST_BOOT, ST_RUN: begin
          hart_running[h] = 1'b1;
          all_halted      = 1'b0;
        end
        default: begin
          hart_running[h] = 1'b0;
        end
      endcase
      if (((state_q[h] == ST_BOOT) || (state_q[h] == ST_RUN)) && halt_req[h]) begin
        state_d[h]   = ST_HALTED;
        boot_pc_d[h] = '0;
      end else if (start_fire && (start_hart == HART_ID_W'(h))) begin
        state_d[h]   = ST_BOOT;
        boot_pc_d[h] = start_pc;
      end else if (slot_boot && (slot_q == HART_ID_W'(h))) begin
        state_d[h]   = ST_RUN;
      end else begin
        state_d[h]   = state_q[h];
      end
    end
  end

  // Slot walk, hart state and registered issue slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_hart_q  <= '0;
      issue_boot_q  <= 1'b0;
      issue_pc_q    <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h]   <= ST_IDLE;
        boot_pc_q[h] <= '0;
      end
    end else begin
      slot_q        <= slot_q + HART_ID_W'(1);
      issue_valid_q <= slot_elig;
      issue_hart_q  <= slot_q;
      issue_boot_q  <= slot_boot;
      issue_pc_q    <= slot_boot ? boot_pc_q[slot_q] : '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h]   <= state_d[h];
        boot_pc_q[h] <= boot_pc_d[h];
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_hart  = issue_hart_q;
  assign issue_boot  = issue_boot_q;
  assign issue_pc    = issue_pc_q;

`ifdef PITO_SCHED_PERF_EN
  logic [31:0] issue_cnt_q [NUM_HARTS];
  logic [31:0] bubble_cnt_q;

  // Counters follow the registered issue slot and survive halt/start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= 32'd0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        issue_cnt_q[h] <= 32'd0;
      end
    end else begin
      if (issue_valid_q) begin
        issue_cnt_q[issue_hart_q] <= issue_cnt_q[issue_hart_q] + 32'd1;
      end else begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt  = issue_cnt_q[perf_sel];
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pito_hart_scheduler.sv
// Directed + randomized bench for pito_hart_scheduler against a lifecycle-level reference model.
module tb_pito_hart_scheduler;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int M_IDLE = 0, M_BOOT = 1, M_RUN = 2, M_HALT = 3;

  logic          clk;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [IW-1:0] start_hart;
  logic [31:0]   start_pc;
  logic [N-1:0]  halt_req;
  logic [N-1:0]  hart_stall;
  logic          issue_valid;
  logic [IW-1:0] issue_hart;
  logic          issue_boot;
  logic [31:0]   issue_pc;
  logic [N-1:0]  hart_running;
  logic          all_halted;

  int tests;
  int fails;

  int          mst  [N];
  logic [31:0] mpc  [N];
  int          mslot;
  logic [N-1:0] r_hr;
  logic [N-1:0] r_st;

  pito_hart_scheduler #(.NUM_HARTS(N), .HART_ID_W(IW), .PC_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_hart   (start_hart),
    .start_pc     (start_pc),
    .halt_req     (halt_req),
    .hart_stall   (hart_stall),
    .issue_valid  (issue_valid),
    .issue_hart   (issue_hart),
    .issue_boot   (issue_boot),
    .issue_pc     (issue_pc),
    .hart_running (hart_running),
    .all_halted   (all_halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < N; h++) begin
      mst[h] = M_IDLE;
      mpc[h] = 32'd0;
    end
    mslot = 0;
  endtask

  // One clock of stimulus; called at a negedge, returns at the next negedge.
  task automatic step(input logic sv, input int sh, input logic [31:0] spc,
                      input logic [N-1:0] hr, input logic [N-1:0] st);
    logic         exp_rdy;
    logic         el;
    logic         e_boot;
    logic [31:0]  e_pc;
    logic [N-1:0] e_run;
    logic         e_allh;
    int           s;
    start_valid = sv;
    start_hart  = sh[IW-1:0];
    start_pc    = spc;
    halt_req    = hr;
    hart_stall  = st;
    #1;
    exp_rdy = (mst[sh] == M_IDLE) || (mst[sh] == M_HALT);
    chk("start_ready", {31'd0, start_ready}, {31'd0, exp_rdy});
    s      = mslot;
    el     = ((mst[s] == M_BOOT) || (mst[s] == M_RUN)) && !st[s] && !hr[s];
    e_boot = el && (mst[s] == M_BOOT);
    e_pc   = e_boot ? mpc[s] : 32'd0;
    for (int h = 0; h < N; h++) begin
      if (((mst[h] == M_BOOT) || (mst[h] == M_RUN)) && hr[h]) mst[h] = M_HALT;
    end
    if (sv && exp_rdy) begin
      mst[sh] = M_BOOT;
      mpc[sh] = spc;
    end
    if (e_boot) mst[s] = M_RUN;
    mslot  = (mslot + 1) % N;
    e_allh = 1'b1;
    for (int h = 0; h < N; h++) begin
      e_run[h] = (mst[h] == M_BOOT) || (mst[h] == M_RUN);
      if (e_run[h]) e_allh = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("issue_valid", {31'd0, issue_valid}, {31'd0, el});
    chk("issue_hart", {29'd0, issue_hart}, s);
    chk("issue_boot", {31'd0, issue_boot}, {31'd0, e_boot});
    chk("issue_pc", issue_pc, e_pc);
    chk("hart_running", {24'd0, hart_running}, {24'd0, e_run});
    chk("all_halted", {31'd0, all_halted}, {31'd0, e_allh});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 32'd0, '0, '0);
  endtask

  task automatic wait_slot(input int target);
    for (int i = 0; i < N && mslot != target; i++) idle(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, issue_valid}, 32'd0);
    chk({tag, "_hart"}, {29'd0, issue_hart}, 32'd0);
    chk({tag, "_boot"}, {31'd0, issue_boot}, 32'd0);
    chk({tag, "_pc"}, issue_pc, 32'd0);
    chk({tag, "_running"}, {24'd0, hart_running}, 32'd0);
    chk({tag, "_allh"}, {31'd0, all_halted}, 32'd1);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    clk         = 1'b0;
    rst_n       = 1'b1;
    start_valid = 1'b0;
    start_hart  = '0;
    start_pc    = 32'd0;
    halt_req    = '0;
    hart_stall  = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #2 chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle walk
    idle(16);

    // start hart 3 while slot 5 is current
    wait_slot(5);
    step(1'b1, 3, 32'h0000_0100, '0, '0);
    idle(20);

    // halt hart 3, then start every hart back-to-back
    step(1'b0, 0, 32'd0, 8'h08, '0);
    for (int h = 0; h < N; h++) step(1'b1, h, 32'h1000 * h, '0, '0);
    idle(20);

    // stall hart 2 for 20 cycles
    for (int i = 0; i < 20; i++) step(1'b0, 0, 32'd0, '0, 8'h04);
    idle(12);

    // halt pulse exactly in hart 5's slot, then restart it
    wait_slot(5);
    step(1'b0, 0, 32'd0, 8'h20, '0);
    step(1'b1, 5, 32'h0000_0200, '0, '0);
    idle(12);

    // start request to running hart 1 is held off until it halts
    for (int i = 0; i < 5; i++) step(1'b1, 1, 32'h0000_0300, '0, '0);
    step(1'b1, 1, 32'h0000_0300, 8'h02, '0);
    step(1'b1, 1, 32'h0000_0300, '0, '0);
    idle(12);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        r_hr[b] = ($urandom_range(0, 15) == 0);
        r_st[b] = ($urandom_range(0, 3) == 0);
      end
      step($urandom_range(0, 1) == 1, $urandom_range(0, N - 1), $urandom, r_hr, r_st);
    end

    // get every hart running so the async reset has something to drop
    step(1'b0, 0, 32'd0, 8'hFF, '0);
    for (int h = 0; h < N; h++) step(1'b1, h, 32'h4000 + h, '0, '0);
    idle(10);
    chk("pre_reset_valid", {31'd0, issue_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
